// File: rtl/parking_gate_controller_if.sv
// Vehicle-request and status bundle between the debouncers, the gate controller and the display/LED logic.
interface parking_gate_controller_if #(
  parameter int CNT_W = 4
);
  logic             entry_pulse;
  logic             exit_pulse;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] free_slots;
  logic             full;
  logic             empty;
  logic             gate_open;
  logic             gate_dir;
  logic             entry_denied;
  logic             exit_error;
  logic             req_dropped;

  modport master (
    output entry_pulse, exit_pulse,
    input  occupancy, free_slots, full, empty, gate_open, gate_dir,
           entry_denied, exit_error, req_dropped
  );

  modport slave (
    input  entry_pulse, exit_pulse,
    output occupancy, free_slots, full, empty, gate_open, gate_dir,
           entry_denied, exit_error, req_dropped
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Occupancy tracker and single shared barrier sequencer; exits win arbitration since they free a slot.
module parking_gate_controller #(
  parameter int CAPACITY         = 8,
  parameter int CNT_W            = 4,
  parameter int GATE_OPEN_CYCLES = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  parking_gate_controller_if.slave    bus
);
  localparam int               TMR_W    = $clog2(GATE_OPEN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY_OPEN = 2'd1,
    ST_EXIT_OPEN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [CNT_W-1:0] r_occ, w_occ_nxt;
  logic [CNT_W-1:0] r_free;
  logic             r_full, r_empty;
  logic             r_pend_en, w_pend_en_nxt;
  logic             r_pend_ex, w_pend_ex_nxt;
  logic             r_gate_open, w_gate_open_nxt;
  logic             r_gate_dir, w_gate_dir_nxt;
  logic             r_denied, w_denied;
  logic             r_err, w_err;
  logic             r_drop, w_drop;
  logic             w_entry_req, w_exit_req;

  assign w_entry_req = bus.entry_pulse | r_pend_en;
  assign w_exit_req  = bus.exit_pulse  | r_pend_ex;

  always_comb begin
    w_state_nxt     = r_state;
    w_tmr_nxt       = r_tmr;
    w_occ_nxt       = r_occ;
    w_pend_en_nxt   = r_pend_en;
    w_pend_ex_nxt   = r_pend_ex;
    w_gate_open_nxt = 1'b0;
    w_gate_dir_nxt  = r_gate_dir;
    w_denied        = 1'b0;
    w_err           = 1'b0;
    w_drop          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (w_exit_req && (r_occ != '0)) begin
          w_state_nxt     = ST_EXIT_OPEN;
          w_occ_nxt       = r_occ - CNT_W'(1);
          w_gate_open_nxt = 1'b1;
          w_gate_dir_nxt  = 1'b1;
          w_pend_ex_nxt   = 1'b0;
          w_pend_en_nxt   = w_entry_req;
        end else begin
          // An exit from an empty lot is rejected and the entry still gets this cycle.
          if (w_exit_req) begin
            w_err         = 1'b1;
            w_pend_ex_nxt = 1'b0;
          end
          if (w_entry_req) begin
            w_pend_en_nxt = 1'b0;
            if (r_occ != CAP_C) begin
              w_state_nxt     = ST_ENTRY_OPEN;
              w_occ_nxt       = r_occ + CNT_W'(1);
              w_gate_open_nxt = 1'b1;
              w_gate_dir_nxt  = 1'b0;
            end else begin
              w_denied = 1'b1;
            end
          end
        end
      end

      ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
        if (r_tmr == TMR_LAST) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt       = r_tmr + TMR_W'(1);
          w_gate_open_nxt = 1'b1;
        end
        // Only one request of each kind can wait; a second one is lost.
        if (bus.entry_pulse) begin
          if (r_pend_en) w_drop        = 1'b1;
          else           w_pend_en_nxt = 1'b1;
        end
        if (bus.exit_pulse) begin
          if (r_pend_ex) w_drop        = 1'b1;
          else           w_pend_ex_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_occ       <= '0;
      r_free      <= CAP_C;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_pend_en   <= 1'b0;
      r_pend_ex   <= 1'b0;
      r_gate_open <= 1'b0;
      r_gate_dir  <= 1'b0;
      r_denied    <= 1'b0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_occ       <= w_occ_nxt;
      r_free      <= CAP_C - w_occ_nxt;
      r_full      <= (w_occ_nxt == CAP_C);
      r_empty     <= (w_occ_nxt == '0);
      r_pend_en   <= w_pend_en_nxt;
      r_pend_ex   <= w_pend_ex_nxt;
      r_gate_open <= w_gate_open_nxt;
      r_gate_dir  <= w_gate_dir_nxt;
      r_denied    <= w_denied;
      r_err       <= w_err;
      r_drop      <= w_drop;
    end
  end

  assign bus.occupancy    = r_occ;
  assign bus.free_slots   = r_free;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.gate_open    = r_gate_open;
  assign bus.gate_dir     = r_gate_dir;
  assign bus.entry_denied = r_denied;
  assign bus.exit_error   = r_err;
  assign bus.req_dropped  = r_drop;
endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed scenarios for the gate controller at CAPACITY=3, GATE_OPEN_CYCLES=4.
module tb_parking_gate_controller;
  localparam int CAP = 3;
  localparam int CW  = 4;
  localparam int GOC = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  parking_gate_controller_if #(.CNT_W(CW)) bus ();

  parking_gate_controller #(
    .CAPACITY(CAP), .CNT_W(CW), .GATE_OPEN_CYCLES(GOC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic en, input logic ex);
    bus.entry_pulse = en;
    bus.exit_pulse  = ex;
    step(1);
    bus.entry_pulse = 1'b0;
    bus.exit_pulse  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.entry_pulse = 1'b0;
    bus.exit_pulse  = 1'b0;

    // 1: reset state then a single entry
    do_reset();
    chk("rst_occ", int'(bus.occupancy), 0);
    chk("rst_free", int'(bus.free_slots), 3);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_gate", int'(bus.gate_open), 0);
    chk("rst_dir", int'(bus.gate_dir), 0);
    pulse(1'b1, 1'b0);
    chk("s1_gate", int'(bus.gate_open), 1);
    chk("s1_dir", int'(bus.gate_dir), 0);
    chk("s1_occ", int'(bus.occupancy), 1);
    chk("s1_free", int'(bus.free_slots), 2);
    chk("s1_empty", int'(bus.empty), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s1_gate_hold", int'(bus.gate_open), 1);
    end
    step(1);
    chk("s1_gate_close", int'(bus.gate_open), 0);

    // 2: fill the lot, fourth entry denied
    step(1);
    pulse(1'b1, 1'b0);
    chk("s2_occ2", int'(bus.occupancy), 2);
    step(5);
    pulse(1'b1, 1'b0);
    chk("s2_occ3", int'(bus.occupancy), 3);
    chk("s2_full", int'(bus.full), 1);
    chk("s2_free0", int'(bus.free_slots), 0);
    step(5);
    pulse(1'b1, 1'b0);
    chk("s2_denied", int'(bus.entry_denied), 1);
    chk("s2_gate", int'(bus.gate_open), 0);
    chk("s2_occ_hold", int'(bus.occupancy), 3);
    step(1);
    chk("s2_denied_clr", int'(bus.entry_denied), 0);
    chk("s2_gate2", int'(bus.gate_open), 0);

    // 3: exit from an empty lot
    do_reset();
    pulse(1'b0, 1'b1);
    chk("s3_err", int'(bus.exit_error), 1);
    chk("s3_gate", int'(bus.gate_open), 0);
    chk("s3_occ", int'(bus.occupancy), 0);
    step(1);
    chk("s3_err_clr", int'(bus.exit_error), 0);
    chk("s3_gate2", int'(bus.gate_open), 0);

    // 4: simultaneous entry and exit with one car inside
    do_reset();
    pulse(1'b1, 1'b0);
    step(5);
    pulse(1'b1, 1'b1);
    chk("s4_gate_ex", int'(bus.gate_open), 1);
    chk("s4_dir_ex", int'(bus.gate_dir), 1);
    chk("s4_occ0", int'(bus.occupancy), 0);
    chk("s4_empty", int'(bus.empty), 1);
    step(3);
    chk("s4_gate_ex4", int'(bus.gate_open), 1);
    step(1);
    chk("s4_gap", int'(bus.gate_open), 0);
    chk("s4_dir_hold", int'(bus.gate_dir), 1);
    step(1);
    chk("s4_gate_en", int'(bus.gate_open), 1);
    chk("s4_dir_en", int'(bus.gate_dir), 0);
    chk("s4_occ1", int'(bus.occupancy), 1);
    step(5);

    // 5: one pending entry latched, the next one dropped
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("s5_no_drop", int'(bus.req_dropped), 0);
    pulse(1'b1, 1'b0);
    chk("s5_drop", int'(bus.req_dropped), 1);
    step(1);
    chk("s5_drop_clr", int'(bus.req_dropped), 0);
    chk("s5_gate_last", int'(bus.gate_open), 1);
    step(1);
    chk("s5_gap", int'(bus.gate_open), 0);
    chk("s5_occ1", int'(bus.occupancy), 1);
    step(1);
    chk("s5_reopen", int'(bus.gate_open), 1);
    chk("s5_occ2", int'(bus.occupancy), 2);
    step(4);
    chk("s5_close", int'(bus.gate_open), 0);
    step(3);
    chk("s5_idle_gate", int'(bus.gate_open), 0);
    chk("s5_final_occ", int'(bus.occupancy), 2);

    // 6: reset mid-window with a pending exit
    do_reset();
    pulse(1'b1, 1'b0);
    step(5);
    pulse(1'b1, 1'b0);
    chk("s6_occ2", int'(bus.occupancy), 2);
    pulse(1'b0, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("s6_gate", int'(bus.gate_open), 0);
    chk("s6_occ", int'(bus.occupancy), 0);
    chk("s6_empty", int'(bus.empty), 1);
    chk("s6_free", int'(bus.free_slots), 3);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("s6_quiet_gate", int'(bus.gate_open), 0);
      chk("s6_quiet_err", int'(bus.exit_error), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Sits directly downstream of the per-button debouncers and consumes their one-clock `entry_pulse` and `exit_pulse` outputs.
- Tracks lot occupancy against a fixed capacity.
- Sequences a single shared barrier gate (open for a fixed time per vehicle).
- Flags full/empty, denied entries and invalid exits for the display and LED logic.

Parameters:
- CAPACITY, 8, number of parking slots; must be ≥ 1.
- CNT_W, 4, width of the occupancy and free-slot outputs; must satisfy 2^CNT_W > CAPACITY.
- GATE_OPEN_CYCLES, 50, clock cycles the gate stays open per vehicle; must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- entry_pulse  input  1  one-clock pulse from the entry debouncer.
- exit_pulse  input  1  one-clock pulse from the exit debouncer.
- occupancy  output  CNT_W  cars currently committed inside.
- free_slots  output  CNT_W  CAPACITY − occupancy.
- full  output  1  high when occupancy == CAPACITY.
- empty  output  1  high when occupancy == 0.
- gate_open  output  1  barrier open command.
- gate_dir  output  1  0 = entry, 1 = exit; valid while gate_open is high, holds its last value otherwise.
- entry_denied  output  1  one-clock pulse: entry refused because the lot is full.
- exit_error  output  1  one-clock pulse: exit requested while the lot is empty.
- req_dropped  output  1  one-clock pulse: request lost because a pending request of the same kind already exists.

Behaviour:
- Reset (synchronous, checked first, overrides everything):
  - State goes to IDLE; timer cleared; pending_entry and pending_exit cleared.
  - occupancy = 0, free_slots = CAPACITY, full = 0, empty = 1.
  - gate_open = 0, gate_dir = 0, all pulse outputs = 0.
  - Reset asserted while the gate is open closes it on the next edge; the in-flight vehicle is not un-counted, since the count is already zeroed.
- All outputs are registered. full, empty and free_slots are derived from the occupancy register and change in the same cycle as occupancy.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN.
- Request sources, evaluated each cycle:
  - exit request = exit_pulse | pending_exit
  - entry request = entry_pulse | pending_entry
- IDLE arbitration (exit has priority because it frees a slot):
  - Exit request with occupancy > 0: go to EXIT_OPEN, occupancy −1, gate_open = 1, gate_dir = 1, clear pending_exit. A simultaneous entry request is latched into pending_entry.
  - Exit request with occupancy == 0: exit_error pulses, pending_exit cleared. The entry request is then evaluated in the same cycle as below.
  - Entry request with occupancy < CAPACITY: go to ENTRY_OPEN, occupancy +1, gate_open = 1, gate_dir = 0, clear pending_entry.
  - Entry request with occupancy == CAPACITY: entry_denied pulses, pending_entry cleared, remain in IDLE.
- Latency:
  - A pulse sampled at edge N in IDLE gives gate_open = 1 and the updated occupancy after edge N.
  - gate_open stays high for exactly GATE_OPEN_CYCLES cycles, then returns to 0.
- ENTRY_OPEN / EXIT_OPEN:
  - Timer counts 0 .. GATE_OPEN_CYCLES−1; on the terminal count, go to IDLE with gate_open = 0.
  - Incoming pulses set the matching pending bit.
  - A pulse arriving while its pending bit is already set is discarded and req_dropped pulses.
  - An entry and an exit pulse in the same cycle are each handled independently.
- Back-to-back operation:
  - After closing, the block spends at least one cycle in IDLE with gate_open = 0.
  - Pending requests are serviced on that IDLE cycle under the IDLE rules.
  - The minimum low gap between two openings is therefore exactly 1 cycle.
- Full/denial checks are made at service time, not at pulse arrival. A pending entry latched while the lot had space is denied if the lot is full when it is serviced.
- occupancy never exceeds CAPACITY and never underflows; there is no wrap-around under any input sequence.
- Timer width is clog2(GATE_OPEN_CYCLES + 1). A GATE_OPEN_CYCLES = 1 configuration must open the gate for exactly one cycle.

Test Plan:
All scenarios use CAPACITY = 3, GATE_OPEN_CYCLES = 4.

1. Reset, then one entry_pulse → gate_open high for 4 cycles starting the cycle after the pulse, gate_dir = 0, occupancy = 1, free_slots = 2, empty = 0.
2. Three entries spaced ≥ 6 cycles apart, then a fourth → occupancy = 3, full = 1; fourth gives entry_denied for 1 cycle, gate stays closed, occupancy stays 3.
3. exit_pulse from reset → exit_error for 1 cycle, gate_open stays 0, occupancy stays 0.
4. occupancy = 1, entry and exit pulses in the same cycle → EXIT_OPEN first (occupancy 0, gate_dir = 1, 4 cycles), 1 cycle closed, then ENTRY_OPEN (occupancy 1, gate_dir = 0).
5. Gate open on entry, two further entry_pulses during the open window → first is latched, second gives req_dropped for 1 cycle; after close, exactly one more entry is served, giving final occupancy = 2.
6. Assert reset for 1 cycle during cycle 2 of ENTRY_OPEN with occupancy = 2 and a pending exit → next cycle gate_open = 0, occupancy = 0, empty = 1, pending cleared; no gate activity follows.
